// File: rtl/ps2_text_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_text_buffer_if
// Description : Read-side bus of the PS/2 text buffer. The display/CPU side
//               (master) drives rd_addr and polls rd_data, wr_ptr and full.
//               The buffer (slave) returns the registered cell contents and
//               its fill state.
//   rd_addr  AW  cell address to read
//   rd_data  DW  registered cell contents, one cycle after rd_addr
//   wr_ptr   AW  next write position
//   full     1   last cell of the buffer holds a character
// Revision    : 1.0  initial release
// ============================================================================
interface ps2_text_buffer_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_ptr;
  logic          full;

  modport master (output rd_addr, input rd_data, input wr_ptr, input full);
  modport slave  (input rd_addr, output rd_data, output wr_ptr, output full);
endinterface
`default_nettype wire

// File: rtl/ps2_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ps2_text_buffer
// Description : PS/2 keyboard receiver (scancode set 2) feeding a text buffer.
//               Frames are received on falling edges of the synchronised PS/2
//               clock, decoded for E0/F0 prefixes and Shift, translated to
//               character codes and written to a RAM. Enter pads the current
//               line with zeros, Backspace steps back.
// Ports       :
//   clk, rst        system clock, asynchronous active-high reset
//   ps2_clk/data    raw PS/2 lines (asynchronous)
//   rd_bus          read port / buffer state (ps2_text_buffer_if.slave)
//   shift_held      a Shift key is currently down
//   key_valid       one-cycle pulse per accepted make code
//   key_code        raw scancode of the last make code
//   key_ext         last make code was E0-prefixed
//   frame_err_cnt   saturating count of bad frames
// Revision    : 1.0  initial release
// ============================================================================
module ps2_text_buffer #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int LINE_LEN = 64,
  parameter int TIMEOUT  = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  ps2_text_buffer_if.slave rd_bus,
  output logic             shift_held,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       frame_err_cnt
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam int            DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_LEN - 1);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  // Built-in key map, indexed {shift, scancode[6:0]}; unmapped codes give 0.
  function automatic logic [7:0] k2n(input logic [7:0] idx);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'h00;
    hi = 8'h00;
    case (idx[6:0])
      7'h1C: lo = "a";  7'h32: lo = "b";  7'h21: lo = "c";  7'h23: lo = "d";
      7'h24: lo = "e";  7'h2B: lo = "f";  7'h34: lo = "g";  7'h33: lo = "h";
      7'h43: lo = "i";  7'h3B: lo = "j";  7'h42: lo = "k";  7'h4B: lo = "l";
      7'h3A: lo = "m";  7'h31: lo = "n";  7'h44: lo = "o";  7'h4D: lo = "p";
      7'h15: lo = "q";  7'h2D: lo = "r";  7'h1B: lo = "s";  7'h2C: lo = "t";
      7'h3C: lo = "u";  7'h2A: lo = "v";  7'h1D: lo = "w";  7'h22: lo = "x";
      7'h35: lo = "y";  7'h1A: lo = "z";
      7'h45: begin lo = "0"; hi = ")"; end
      7'h16: begin lo = "1"; hi = "!"; end
      7'h1E: begin lo = "2"; hi = "@"; end
      7'h26: begin lo = "3"; hi = "#"; end
      7'h25: begin lo = "4"; hi = "$"; end
      7'h2E: begin lo = "5"; hi = "%"; end
      7'h36: begin lo = "6"; hi = "^"; end
      7'h3D: begin lo = "7"; hi = "&"; end
      7'h3E: begin lo = "8"; hi = "*"; end
      7'h46: begin lo = "9"; hi = "("; end
      7'h29: begin lo = " "; hi = " "; end
      default: ;
    endcase
    if (lo >= "a" && lo <= "z") hi = lo - 8'h20;
    return idx[7] ? hi : lo;
  endfunction

  // --------------------------------------------------------------------------
  // Input synchronisers; s3 only delays the clock for falling-edge detection.
  // --------------------------------------------------------------------------
  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
  logic ps2_dat_s1_q, ps2_dat_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_s1_q <= 1'b1;
      ps2_clk_s2_q <= 1'b1;
      ps2_clk_s3_q <= 1'b1;
      ps2_dat_s1_q <= 1'b1;
      ps2_dat_s2_q <= 1'b1;
    end else begin
      ps2_clk_s1_q <= ps2_clk;
      ps2_clk_s2_q <= ps2_clk_s1_q;
      ps2_clk_s3_q <= ps2_clk_s2_q;
      ps2_dat_s1_q <= ps2_data;
      ps2_dat_s2_q <= ps2_dat_s1_q;
    end
  end

  logic ps2_fall;
  assign ps2_fall = ps2_clk_s3_q & ~ps2_clk_s2_q;

  // --------------------------------------------------------------------------
  // Frame receiver
  // --------------------------------------------------------------------------
  logic [1:0]    rx_state_q, rx_state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rx_timeout;
  logic          rx_byte_valid;
  logic          rx_frame_err;

  // The timer runs only inside a frame and restarts on every falling edge.
  assign rx_timeout = (rx_state_q != RX_IDLE) && !ps2_fall &&
                      (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_q <= RX_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    if (rx_timeout) begin
      rx_state_d = RX_IDLE;
    end else if (ps2_fall) begin
      case (rx_state_q)
        RX_IDLE:   if (!ps2_dat_s2_q) rx_state_d = RX_DATA;
        RX_DATA:   if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        RX_PARITY: rx_state_d = RX_STOP;
        RX_STOP:   rx_state_d = RX_IDLE;
        default:   rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_byte_valid = 1'b0;
    rx_frame_err  = 1'b0;
    if (ps2_fall && rx_state_q == RX_STOP) begin
      // Odd parity over data+parity and a high stop bit.
      if ((^{shreg_q, par_q}) && ps2_dat_s2_q) rx_byte_valid = 1'b1;
      else                                     rx_frame_err  = 1'b1;
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    timer_d   = (rx_state_q == RX_IDLE || ps2_fall) ? '0 : timer_q + 1'b1;
    if (ps2_fall) begin
      case (rx_state_q)
        RX_IDLE:   bit_cnt_d = 3'd0;
        RX_DATA: begin
          shreg_d   = {ps2_dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        RX_PARITY: par_d = ps2_dat_s2_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      timer_q   <= timer_d;
    end
  end

  // --------------------------------------------------------------------------
  // Decoder, buffer write pointer and line padding
  // --------------------------------------------------------------------------
  logic          fill_q, fill_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          shift_q, shift_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          full_q, full_d;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          dec_valid;
  logic [7:0]    dec_byte;
  logic          is_shift;
  logic [AW-1:0] ptr_inc;

  assign ptr_inc = wr_ptr_q + 1'b1;

  always_comb begin
    fill_d       = fill_q;
    pend_valid_d = pend_valid_q;
    pend_byte_d  = pend_byte_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    shift_d      = shift_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    err_cnt_d    = err_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    full_d       = full_q;
    mem_we       = 1'b0;
    mem_wdata    = '0;

    // A held byte always goes first; a byte arriving while padding (or
    // while another byte is still held) waits in the pending register.
    dec_valid = !fill_q && (pend_valid_q || rx_byte_valid);
    dec_byte  = pend_valid_q ? pend_byte_q : shreg_q;
    is_shift  = (dec_byte == 8'h12) || (dec_byte == 8'h59);

    if (rx_byte_valid && (fill_q || pend_valid_q)) begin
      pend_valid_d = 1'b1;
      pend_byte_d  = shreg_q;
    end else if (dec_valid && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end

    if (rx_frame_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    if (fill_q) begin
      // Pad the current cell, then stop at the next line boundary or at the
      // end of the buffer.
      mem_we = 1'b1;
      if (wr_ptr_q == LAST_ADDR) begin
        full_d = 1'b1;
        fill_d = 1'b0;
      end else begin
        wr_ptr_d = ptr_inc;
        if ((ptr_inc & LINE_MASK) == '0) fill_d = 1'b0;
      end
    end else if (dec_valid) begin
      if (dec_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else if (dec_byte == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        if (!ext_q && is_shift) shift_d = 1'b0;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        key_valid_d = 1'b1;
        key_code_d  = dec_byte;
        key_ext_d   = ext_q;
        ext_d       = 1'b0;
        if (!ext_q && !dec_byte[7]) begin
          if (is_shift) begin
            shift_d = 1'b1;
          end else if (dec_byte == 8'h5A) begin
            if (!full_q) fill_d = 1'b1;
          end else if (dec_byte == 8'h66) begin
            // From full, backspace just invalidates the last cell.
            if (full_q)                full_d   = 1'b0;
            else if (wr_ptr_q != '0)   wr_ptr_d = wr_ptr_q - 1'b1;
          end else if (!full_q) begin
            mem_we    = 1'b1;
            mem_wdata = DW'(k2n({shift_q, dec_byte[6:0]}));
            if (wr_ptr_q == LAST_ADDR) full_d   = 1'b1;
            else                       wr_ptr_d = ptr_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      shift_q      <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      err_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      full_q       <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      pend_valid_q <= pend_valid_d;
      pend_byte_q  <= pend_byte_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      shift_q      <= shift_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      err_cnt_q    <= err_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      full_q       <= full_d;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer RAM (not reset) and registered read port. Validity is judged from
  // the pre-write pointer state, so a same-cycle write is not visible yet.
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= mem_wdata;
  end

  always_comb begin
    rd_valid  = (rd_bus.rd_addr < wr_ptr_q) ||
                (full_q && rd_bus.rd_addr == LAST_ADDR);
    rd_data_d = rd_valid ? mem[rd_bus.rd_addr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_bus.rd_data = rd_data_q;
  assign rd_bus.wr_ptr  = wr_ptr_q;
  assign rd_bus.full    = full_q;
  assign shift_held     = shift_q;
  assign key_valid      = key_valid_q;
  assign key_code       = key_code_q;
  assign key_ext        = key_ext_q;
  assign frame_err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_text_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_text_buffer
// Description : Directed bench for ps2_text_buffer. dut0 uses the default
//               geometry (AW=10, LINE_LEN=64); dut1 is a small buffer
//               (AW=4, LINE_LEN=8) for full/backspace/last-line behaviour.
//               Both use a short TIMEOUT so a stalled frame expires quickly.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_text_buffer;

  localparam int TO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic pc0 = 1'b1, pd0 = 1'b1, pc1 = 1'b1, pd1 = 1'b1;
  logic sh0, kv0, ke0, sh1, kv1, ke1;
  logic [7:0] kc0, ec0, kc1, ec1;

  ps2_text_buffer_if #(.AW(10), .DW(8)) bus0 ();
  ps2_text_buffer_if #(.AW(4),  .DW(8)) bus1 ();

  ps2_text_buffer #(.AW(10), .DW(8), .LINE_LEN(64), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .ps2_clk(pc0), .ps2_data(pd0), .rd_bus(bus0),
    .shift_held(sh0), .key_valid(kv0), .key_code(kc0), .key_ext(ke0),
    .frame_err_cnt(ec0)
  );

  ps2_text_buffer #(.AW(4), .DW(8), .LINE_LEN(8), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst), .ps2_clk(pc1), .ps2_data(pd1), .rd_bus(bus1),
    .shift_held(sh1), .key_valid(kv1), .key_code(kc1), .key_ext(ke1),
    .frame_err_cnt(ec1)
  );

  int tests = 0;
  int fails = 0;

  // Pulse counters and timestamps, sampled on the falling clock edge.
  int         cyc     = 0;
  int         kv_cnt0 = 0;
  int         kv_cnt1 = 0;
  int         kv_cyc0 = 0;
  int         wp_cyc0 = 0;
  logic [9:0] wp_prev0 = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (kv0) begin
      kv_cnt0 <= kv_cnt0 + 1;
      kv_cyc0 <= cyc;
    end
    if (kv1) kv_cnt1 <= kv_cnt1 + 1;
    wp_prev0 <= bus0.wr_ptr;
    if (bus0.wr_ptr != wp_prev0) wp_cyc0 <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int d, input logic c, input logic v);
    if (d == 0) begin pc0 = c; pd0 = v; end
    else        begin pc1 = c; pd1 = v; end
  endtask

  // Sends the first n bits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input int d, input logic [7:0] b, input int n,
                           input bit badpar, input int h);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      drive(d, 1'b1, f[i]);
      cycles(h);
      drive(d, 1'b0, f[i]);
      cycles(h);
      drive(d, 1'b1, f[i]);
    end
    drive(d, 1'b1, 1'b1);
    cycles(h);
  endtask

  task automatic send(input int d, input logic [7:0] b, input int h);
    send_bits(d, b, 11, 1'b0, h);
  endtask

  task automatic chk_rd(input int d, input int a, input logic [7:0] exp, input string tag);
    if (d == 0) bus0.rd_addr = a[9:0];
    else        bus1.rd_addr = a[3:0];
    cycles(1);
    chk(tag, (d == 0) ? bus0.rd_data : bus1.rd_data, exp);
  endtask

  int kb;

  initial begin
    rst = 1'b1;
    bus0.rd_addr = '0;
    bus1.rd_addr = '0;
    cycles(3);
    chk("rst_wr_ptr0", bus0.wr_ptr, 0);
    chk("rst_full0",   bus0.full, 0);
    chk("rst_rd0",     bus0.rd_data, 0);
    chk("rst_kv0",     kv0, 0);
    chk("rst_kc0",     kc0, 0);
    chk("rst_err0",    ec0, 0);
    chk("rst_wr_ptr1", bus1.wr_ptr, 0);
    rst = 1'b0;
    cycles(3);

    // T1: single make code
    kb = kv_cnt0;
    send(0, 8'h1C, 5);
    cycles(4);
    chk("t1_kv_pulses", kv_cnt0 - kb, 1);
    chk("t1_key_code",  kc0, 8'h1C);
    chk("t1_wr_ptr",    bus0.wr_ptr, 1);
    chk_rd(0, 0, 8'h61, "t1_rd0");

    // T2: shifted character, then releases
    kb = kv_cnt0;
    send(0, 8'h12, 5);
    cycles(2);
    chk("t2_shift_on", sh0, 1);
    send(0, 8'h1C, 5);
    send(0, 8'hF0, 5);
    send(0, 8'h1C, 5);
    send(0, 8'hF0, 5);
    send(0, 8'h12, 5);
    cycles(4);
    chk("t2_shift_off",  sh0, 0);
    chk("t2_kv_pulses",  kv_cnt0 - kb, 2);
    chk("t2_wr_ptr",     bus0.wr_ptr, 2);
    chk_rd(0, 1, 8'h41, "t2_rd1");

    // T3: bad parity, then extended make
    kb = kv_cnt0;
    send_bits(0, 8'h1C, 11, 1'b1, 5);
    cycles(4);
    chk("t3_err_cnt",   ec0, 1);
    chk("t3_wr_ptr",    bus0.wr_ptr, 2);
    chk("t3_no_kv",     kv_cnt0 - kb, 0);
    send(0, 8'hE0, 5);
    send(0, 8'h75, 5);
    cycles(4);
    chk("t3_key_ext",   ke0, 1);
    chk("t3_key_code",  kc0, 8'h75);
    chk("t3_wr_ptr_e0", bus0.wr_ptr, 2);
    send(0, 8'h1C, 5);
    cycles(4);
    chk("t3_key_ext_clr", ke0, 0);
    chk("t3_wr_ptr3",     bus0.wr_ptr, 3);

    // T4: Enter pads 3..63, then Enter at a line start with a byte mid-fill
    send(0, 8'h5A, 5);
    cycles(80);
    chk("t4_wr_ptr64",   bus0.wr_ptr, 64);
    chk("t4_fill_cycles", wp_cyc0 - kv_cyc0, 61);
    chk_rd(0, 2, 8'h61, "t4_rd2");
    for (int a = 3; a < 64; a++) chk_rd(0, a, 8'h00, $sformatf("t4_pad_%0d", a));
    kb = kv_cnt0;
    send(0, 8'h5A, 2);
    send(0, 8'h1C, 2);
    cycles(120);
    chk("t4_kv_pulses",  kv_cnt0 - kb, 2);
    chk("t4_wr_ptr129",  bus0.wr_ptr, 129);
    chk_rd(0, 128, 8'h61, "t4_rd128");
    chk_rd(0, 64,  8'h00, "t4_rd64");
    chk_rd(0, 127, 8'h00, "t4_rd127");
    chk_rd(0, 129, 8'h00, "t4_rd_at_wr_ptr");

    // T5: small buffer fills, drops, backspaces, pads the last line
    for (int i = 0; i < 15; i++) send(1, 8'h1C, 2);
    send(1, 8'h1B, 2);
    cycles(4);
    chk("t5_full",       bus1.full, 1);
    chk("t5_wr_ptr15",   bus1.wr_ptr, 15);
    chk_rd(1, 15, 8'h73, "t5_rd15");
    chk_rd(1, 0,  8'h61, "t5_rd0");
    send(1, 8'h1C, 2);
    send(1, 8'h5A, 2);
    cycles(20);
    chk("t5_full_hold",  bus1.full, 1);
    chk("t5_wr_hold",    bus1.wr_ptr, 15);
    chk_rd(1, 15, 8'h73, "t5_rd15_kept");
    send(1, 8'h66, 2);
    cycles(4);
    chk("t5_bs_full",    bus1.full, 0);
    chk("t5_bs_wr15",    bus1.wr_ptr, 15);
    chk_rd(1, 15, 8'h00, "t5_rd15_invalid");
    chk_rd(1, 14, 8'h61, "t5_rd14");
    send(1, 8'h66, 2);
    cycles(4);
    chk("t5_bs_wr14",    bus1.wr_ptr, 14);
    chk_rd(1, 14, 8'h00, "t5_rd14_invalid");
    send(1, 8'h5A, 2);
    cycles(20);
    chk("t5_pad_full",   bus1.full, 1);
    chk("t5_pad_wr15",   bus1.wr_ptr, 15);
    chk_rd(1, 15, 8'h00, "t5_pad_rd15");
    chk_rd(1, 13, 8'h61, "t5_rd13");

    // T6: reset mid-frame, then a timed-out partial frame
    send_bits(0, 8'h1C, 5, 1'b0, 5);
    rst = 1'b1;
    cycles(2);
    chk("t6_rst_wr_ptr", bus0.wr_ptr, 0);
    chk("t6_rst_kc",     kc0, 0);
    chk("t6_rst_err",    ec0, 0);
    chk("t6_rst_ke",     ke0, 0);
    chk("t6_rst_rd",     bus0.rd_data, 0);
    chk("t6_rst_full1",  bus1.full, 0);
    rst = 1'b0;
    cycles(3);
    send(0, 8'h1C, 5);
    cycles(4);
    chk("t6_wr_ptr1",    bus0.wr_ptr, 1);
    chk("t6_key_code",   kc0, 8'h1C);
    chk_rd(0, 0, 8'h61, "t6_rd0");
    send_bits(0, 8'h1B, 4, 1'b0, 5);
    cycles(TO + 50);
    send(0, 8'h1C, 5);
    cycles(4);
    chk("t6_to_wr_ptr",  bus0.wr_ptr, 2);
    chk("t6_to_err",     ec0, 0);
    chk_rd(0, 1, 8'h61, "t6_to_rd1");
    kb = kv_cnt1;
    send(1, 8'h66, 2);
    cycles(4);
    chk("t6_bs_at0_wr",  bus1.wr_ptr, 0);
    chk("t6_bs_at0_kv",  kv_cnt1 - kb, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
